// File: rtl/button_conditioner.sv
// Two-channel push-button conditioner: synchronize, debounce, one shift pulse per press.
// Define BUTTON_REPEAT_EN to build the hold-to-repeat pulse generator in each channel.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 12500000,
   parameter int REPEAT_PERIOD   = 2500000
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_left,
   input  logic btn_right,
   output logic shift_left,
   output logic shift_right,
   output logic left_level,
   output logic right_level
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2");
   end
   if (REPEAT_DELAY < 2) begin : g_bad_delay
      $error("button_conditioner: REPEAT_DELAY must be >= 2");
   end
   if (REPEAT_PERIOD < 2) begin : g_bad_period
      $error("button_conditioner: REPEAT_PERIOD must be >= 2");
   end

   // Channel 0 is left, channel 1 is right.
   logic [1:0] btn_raw;
   logic [1:0] level_vec;
   logic [1:0] evt_vec;
   logic [1:0] shift_q;
   logic [1:0] shift_d;

   assign btn_raw = {btn_right, btn_left};

   for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic          s1_q;
      logic          s2_q;
      logic          level_q;
      logic          level_d;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          disagree;
      logic          expire;
      logic          press;
      logic          fall;

      always_comb begin
         disagree = s2_q ^ level_q;
         expire   = disagree && (cnt_q == DB_LAST);
         press    = expire && s2_q;
         fall     = expire && !s2_q;
         level_d  = level_q;
         cnt_d    = '0;
         if (expire) begin
            level_d = s2_q;
         end else if (disagree) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
         end else begin
            s1_q    <= btn_raw[gi];
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
         end
      end

      assign level_vec[gi] = level_q;

`ifdef BUTTON_REPEAT_EN
      localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RW   = $clog2(RMAX);
      localparam logic [RW-1:0] RD_LOAD = RW'(REPEAT_DELAY - 1);
      localparam logic [RW-1:0] RP_LOAD = RW'(REPEAT_PERIOD - 1);

      logic [RW-1:0] rep_q;
      logic [RW-1:0] rep_d;
      logic          rep_fire;

      // Counter reaching zero marks a repeat edge; the edge that drops the level never repeats.
      always_comb begin
         rep_d    = rep_q;
         rep_fire = 1'b0;
         if (press) begin
            rep_d = RD_LOAD;
         end else if (!level_q) begin
            rep_d = '0;
         end else if (rep_q == '0) begin
            rep_fire = !fall;
            rep_d    = RP_LOAD;
         end else begin
            rep_d = rep_q - 1'b1;
         end
      end

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            rep_q <= '0;
         end else begin
            rep_q <= rep_d;
         end
      end

      assign evt_vec[gi] = press | rep_fire;
`else
      assign evt_vec[gi] = press;
`endif
   end

   // Simultaneous events on both channels are ambiguous, so both are dropped.
   always_comb begin
      shift_d[0] = evt_vec[0] & ~evt_vec[1];
      shift_d[1] = evt_vec[1] & ~evt_vec[0];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         shift_q <= 2'b00;
      end else begin
         shift_q <= shift_d;
      end
   end

   assign shift_left  = shift_q[0];
   assign shift_right = shift_q[1];
   assign left_level  = level_vec[0];
   assign right_level = level_vec[1];

endmodule
